// File: rtl/id_ex_forward_if.sv
// ID/EX stage bus: decoded instruction in, forwarding sources in, EX operands and controls out.
interface id_ex_forward_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned REGBITS = 5
);
   logic               id_valid;
   logic [REGBITS-1:0] id_rs;
   logic [REGBITS-1:0] id_rt;
   logic [REGBITS-1:0] id_rd;
   logic [WIDTH-1:0]   id_rd1;
   logic [WIDTH-1:0]   id_rd2;
   logic [WIDTH-1:0]   id_imm;
   logic [2:0]         id_alucontrol;
   logic               id_alusrc;
   logic               id_regdst;
   logic               id_regwrite;
   logic               id_memtoreg;
   logic               id_memwrite;
   logic               flush_ex;
   logic               mem_regwrite;
   logic [REGBITS-1:0] mem_writereg;
   logic [WIDTH-1:0]   mem_aluresult;
   logic               wb_regwrite;
   logic [REGBITS-1:0] wb_writereg;
   logic [WIDTH-1:0]   wb_result;
   logic               stall_id;
   logic               ex_valid;
   logic               ex_regwrite;
   logic               ex_memtoreg;
   logic               ex_memwrite;
   logic [2:0]         ex_alucontrol;
   logic               ex_addsub;
   logic [REGBITS-1:0] ex_writereg;
   logic [WIDTH-1:0]   ex_srca;
   logic [WIDTH-1:0]   ex_srcb;
   logic [WIDTH-1:0]   ex_writedata;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_alucontrol,
             id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, flush_ex,
             mem_regwrite, mem_writereg, mem_aluresult, wb_regwrite, wb_writereg, wb_result,
      input  stall_id, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_alucontrol,
             ex_addsub, ex_writereg, ex_srca, ex_srcb, ex_writedata
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_alucontrol,
             id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, flush_ex,
             mem_regwrite, mem_writereg, mem_aluresult, wb_regwrite, wb_writereg, wb_result,
      output stall_id, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_alucontrol,
             ex_addsub, ex_writereg, ex_srca, ex_srcb, ex_writedata
   );
endinterface

// File: rtl/id_ex_forward.sv
// Execute-entry stage: ID/EX pipeline register, MEM/WB operand forwarding,
// load-use stall detection and bubble insertion for stalls and flushes.
module id_ex_forward #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned REGBITS = 5
) (
   input logic             clk,
   input logic             reset_n,
   id_ex_forward_if.slave  bus
);

   logic               valid_q, valid_d;
   logic [REGBITS-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [WIDTH-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [2:0]         alucontrol_q, alucontrol_d;
   logic               alusrc_q, alusrc_d, regdst_q, regdst_d;
   logic               regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, memwrite_q, memwrite_d;

   logic [REGBITS-1:0] writereg;
   logic               load_use;
   logic               stall;
   logic [WIDTH-1:0]   fwd_a, fwd_b;

   assign writereg = regdst_q ? rd_q : rt_q;

   // Conservative load-use check: rt is compared even when it is a destination.
   assign load_use = bus.id_valid & valid_q & memtoreg_q & (writereg != '0) &
                     ((writereg == bus.id_rs) | (writereg == bus.id_rt));
   assign stall    = load_use & ~bus.flush_ex;

   // Next stage contents: a bubble on flush or stall, otherwise the ID instruction.
   always_comb begin
      valid_d      = 1'b0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      imm_d        = '0;
      alucontrol_d = 3'b000;
      alusrc_d     = 1'b0;
      regdst_d     = 1'b0;
      regwrite_d   = 1'b0;
      memtoreg_d   = 1'b0;
      memwrite_d   = 1'b0;
      if (!bus.flush_ex && !stall) begin
         valid_d      = bus.id_valid;
         rs_d         = bus.id_rs;
         rt_d         = bus.id_rt;
         rd_d         = bus.id_rd;
         rd1_d        = bus.id_rd1;
         rd2_d        = bus.id_rd2;
         imm_d        = bus.id_imm;
         alucontrol_d = bus.id_alucontrol;
         alusrc_d     = bus.id_alusrc;
         regdst_d     = bus.id_regdst;
         regwrite_d   = bus.id_regwrite & bus.id_valid;
         memtoreg_d   = bus.id_memtoreg;
         memwrite_d   = bus.id_memwrite & bus.id_valid;
      end
   end

   // ID/EX stage register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q      <= 1'b0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         alucontrol_q <= 3'b000;
         alusrc_q     <= 1'b0;
         regdst_q     <= 1'b0;
         regwrite_q   <= 1'b0;
         memtoreg_q   <= 1'b0;
         memwrite_q   <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         alucontrol_q <= alucontrol_d;
         alusrc_q     <= alusrc_d;
         regdst_q     <= regdst_d;
         regwrite_q   <= regwrite_d;
         memtoreg_q   <= memtoreg_d;
         memwrite_q   <= memwrite_d;
      end
   end

   // Operand A forwarding: MEM beats WB, $0 never forwarded.
   always_comb begin
      fwd_a = rd1_q;
      if (bus.mem_regwrite && (bus.mem_writereg != '0) && (bus.mem_writereg == rs_q))
         fwd_a = bus.mem_aluresult;
      else if (bus.wb_regwrite && (bus.wb_writereg != '0) && (bus.wb_writereg == rs_q))
         fwd_a = bus.wb_result;
   end

   // Operand B forwarding, same rule against rt.
   always_comb begin
      fwd_b = rd2_q;
      if (bus.mem_regwrite && (bus.mem_writereg != '0) && (bus.mem_writereg == rt_q))
         fwd_b = bus.mem_aluresult;
      else if (bus.wb_regwrite && (bus.wb_writereg != '0) && (bus.wb_writereg == rt_q))
         fwd_b = bus.wb_result;
   end

   assign bus.stall_id      = stall;
   assign bus.ex_valid      = valid_q;
   assign bus.ex_regwrite   = regwrite_q;
   assign bus.ex_memtoreg   = memtoreg_q;
   assign bus.ex_memwrite   = memwrite_q;
   assign bus.ex_alucontrol = alucontrol_q;
   assign bus.ex_addsub     = alucontrol_q[2] & alucontrol_q[1];
   assign bus.ex_writereg   = writereg;
   assign bus.ex_srca       = fwd_a;
   assign bus.ex_writedata  = fwd_b;
   assign bus.ex_srcb       = alusrc_q ? imm_q : fwd_b;

endmodule

// File: doc/id_ex_forward.md
# id_ex_forward

Execute-entry stage of the pipelined MIPS datapath. Registers the decoded instruction from ID and drives the operand/control inputs of the 32-bit ALU built from 1-bit slices: SrcA, SrcB, ALUcontrol and the add/subtract signal. It resolves data hazards by forwarding from MEM and WB. It detects load-use hazards, stalls ID, and inserts bubbles for stalls and branch flushes.

## Interface
- WIDTH, 32, datapath width
- REGBITS, 5, register-index width
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REGBITS  source/destination indices
- id_rd1, id_rd2  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_alucontrol  in  3  ALU operation: 000 AND, 001 OR, 010 ADD, 011 NOR, 100 XOR, 101 NAND, 110 SUB, 111 SLT
- id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite  in  1  decoded controls
- flush_ex  in  1  branch/jump taken; kill instruction entering EX
- mem_regwrite  in  1; mem_writereg  in  REGBITS; mem_aluresult  in  WIDTH  MEM-stage forwarding source
- wb_regwrite  in  1; wb_writereg  in  REGBITS; wb_result  in  WIDTH  WB-stage forwarding source
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite  out  1  registered EX controls
- ex_alucontrol  out  3  registered; drives ALUcontrol of every slice
- ex_addsub  out  1  1 when ex_alucontrol is 110 or 111; drives addSubSignal and bit-0 cin
- ex_writereg  out  REGBITS  ex_regdst ? ex_rd : ex_rt
- ex_srca, ex_srcb, ex_writedata  out  WIDTH  forwarded operands (combinational from stage registers)

## Operation
- Stage registers: valid, rs, rt, rd, rd1, rd2, imm, alucontrol, alusrc, regdst, regwrite, memtoreg, memwrite.
- Next-state priority: reset > flush_ex > stall_id > load from ID.
  - Reset, flush or stall: load a bubble. valid, regwrite, memtoreg and memwrite are 0; all other fields are 0.
  - Load: capture all id_* fields. If id_valid=0, regwrite and memwrite are also forced to 0.
- Load-use detection (combinational): stall_id = id_valid & ex_valid & ex_memtoreg & (ex_writereg != 0) & (ex_writereg == id_rs | ex_writereg == id_rt). The rt comparison is conservative; an I-type rt destination may also stall.
- Stall_id is gated by flush_ex. When flush_ex=1, stall_id=0, because the ID instruction is discarded by the flush.
- Forward A:
  - mem_regwrite & mem_writereg != 0 & mem_writereg == ex_rs → mem_aluresult
  - else wb_regwrite & wb_writereg != 0 & wb_writereg == ex_rs → wb_result
  - else ex_rd1
  - MEM has priority over WB.
- Forward B: the same rule against ex_rt gives ex_writedata.
- ex_srcb = ex_alusrc ? ex_imm : ex_writedata.
- ex_srca = forward-A result.
- Register $0 is never forwarded. Index 0 always selects the register-file value.
- Forwarding applies even when ex_valid=0. Outputs are don't-care downstream because the bubble controls are 0.

## Timing
- After reset (reset_n=0 at an edge), all registered outputs are 0: ex_valid=0, ex_alucontrol=000, ex_addsub=0, ex_writereg=0.
- With no forwarding active after reset, ex_srca=ex_srcb=ex_writedata=0.
- Latency: ID fields appear at EX outputs one cycle after the capturing edge.
- Forwarding and stall_id are the same-cycle combinational response to the current inputs.
- Load-use costs exactly one bubble:
  - cycle n: lw in EX, dependent instruction in ID → stall_id=1
  - cycle n+1: lw in MEM, bubble in EX, dependent still in ID → stall_id=0
  - cycle n+2: dependent in EX, lw in WB → forward from WB
- Back-to-back loads each stall independently.
- Reset_n low mid-stall or mid-flush: the next edge clears all stage state, and stall_id falls combinationally.
- Simultaneous flush_ex and stall condition: the flush wins; a bubble is loaded and stall_id=0.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with random id_* → ex_valid=0, ex_regwrite=0, ex_alucontrol=000, ex_srca=0, stall_id=0.
- EX/MEM forward: add $3 is in MEM with mem_aluresult=0x00000010; EX holds sub $4,$3,$5 with rd1=0xDEAD, rd2=7 → ex_srca=0x10, ex_srcb=7, ex_alucontrol=110, ex_addsub=1.
- Priority and $0: mem and wb both write $3 (0x10 vs 0x20) → MEM value 0x10 chosen. Repeat with rs=0 and a matching writereg=0 → rd1 passes through.
- Load-use: lw $2 in EX, ID has add $6,$2,$1 → stall_id=1 for 1 cycle and ex_valid=0 next cycle. Then the add reaches EX with wb_result=0x1234 forwarded to ex_srca.
- Flush over stall: set up the load-use case with flush_ex=1 → stall_id=0 and the bubble is loaded (ex_valid=0, ex_memwrite=0).
- Immediate path: addi with alusrc=1, imm=0xFFFFFFFC, rt matches mem_writereg → ex_srcb=0xFFFFFFFC and ex_writedata=mem_aluresult.
